hazard_unit_v2: RTL and testbench

Parametrised stall/flush controller for the pipelined MIPS CPU, sitting beside the D stage. It compares D-stage source registers and Tuse against Tnew from any number of producer stages. It also tracks a multi-cycle multiply/divide unit with an internal busy counter, and applies an external flush request. It drives write-enable and clear for the PC and every pipeline register, and can optionally count stall cycles for performance measurement.

---
 rtl/hazard_unit_v2.sv | 177 +++++++++++++++++
 tb/tb_hazard_unit_v2.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_v2.sv
// -----------------------------------------------------------------------------
// hazard_unit_v2
//
// Stall/flush controller for the pipelined MIPS CPU, placed beside the D stage.
// It compares the D-stage source registers and their Tuse against the Tnew of
// NUM_PROD producer stages (index 0 = E, 1 = M, ...). It tracks the multi-cycle
// multiply/divide unit with an internal busy counter and applies an external
// flush request. It produces write-enables and clears for the PC and every
// pipeline register.
//
// Optional feature macro: STALL_CNT_EN
//   defined   -> SCW-bit saturating stall_cnt register is built
//   undefined -> no counter flops, stall_cnt tied to 0
//
// Ports:
//   clk, reset (async, active-low)
//   D_rs_Tuse, D_rt_Tuse  : cycles until D needs rs / rt
//   D_A1, D_A2            : D rs / rt addresses
//   P_A3, P_Tnew          : packed producer destinations / Tnew (slice i)
//   P_RegWrite            : producer i writes its A3
//   D_md_use              : D instruction uses the mult/div unit
//   E_md_start, E_md_is_div : mult/div launched from E (and whether divide)
//   flush_req             : exception/eret flush request
//   stall                 : D held this cycle
//   *_RegWE / *_clear     : pipeline register write enables / clears
//   md_busy               : mult/div counter non-zero
//   stall_cnt             : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_unit_v2 #(
   parameter int NUM_PROD   = 2,
   parameter int TW         = 4,
   parameter int AW         = 5,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int SCW        = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TW-1:0]          D_rs_Tuse,
   input  logic [TW-1:0]          D_rt_Tuse,
   input  logic [AW-1:0]          D_A1,
   input  logic [AW-1:0]          D_A2,
   input  logic [NUM_PROD*AW-1:0] P_A3,
   input  logic [NUM_PROD*TW-1:0] P_Tnew,
   input  logic [NUM_PROD-1:0]    P_RegWrite,
   input  logic                   D_md_use,
   input  logic                   E_md_start,
   input  logic                   E_md_is_div,
   input  logic                   flush_req,
   output logic                   stall,
   output logic                   PC_RegWE,
   output logic                   F_D_RegWE,
   output logic                   F_D_clear,
   output logic                   D_E_RegWE,
   output logic                   D_E_clear,
   output logic                   E_M_RegWE,
   output logic                   E_M_clear,
   output logic                   M_W_RegWE,
   output logic                   M_W_clear,
   output logic                   md_busy,
   output logic [SCW-1:0]         stall_cnt
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);

   // One source-vs-producer comparison; $zero never creates a hazard.
   function automatic logic src_hit(
      input logic [AW-1:0] src_a,
      input logic [TW-1:0] tuse,
      input logic [AW-1:0] dst_a,
      input logic [TW-1:0] tnew,
      input logic          we
   );
      src_hit = (src_a != {AW{1'b0}}) & we & (src_a == dst_a) & (tuse < tnew);
   endfunction

   logic [CW-1:0] md_cnt_q;
   logic [CW-1:0] md_cnt_d;
   logic          reg_stall_s;
   logic          md_stall_s;
   logic          stall_s;
   logic          md_busy_s;

   // Register hazard: OR of every producer/source hit.
   always_comb begin
      reg_stall_s = 1'b0;
      for (int i = 0; i < NUM_PROD; i++) begin
         reg_stall_s = reg_stall_s
                     | src_hit(D_A1, D_rs_Tuse, P_A3[i*AW +: AW], P_Tnew[i*TW +: TW], P_RegWrite[i])
                     | src_hit(D_A2, D_rt_Tuse, P_A3[i*AW +: AW], P_Tnew[i*TW +: TW], P_RegWrite[i]);
      end
   end

   assign md_busy_s  = (md_cnt_q != {CW{1'b0}});
   // E_md_start counts as busy too: the operation has not loaded the counter yet.
   assign md_stall_s = D_md_use & (md_busy_s | E_md_start);
   assign stall_s    = (reg_stall_s | md_stall_s) & ~flush_req;

   // Pipeline control outputs; flush overrides stall.
   always_comb begin
      PC_RegWE  = 1'b1;
      F_D_RegWE = 1'b1;
      F_D_clear = 1'b0;
      D_E_RegWE = 1'b1;
      D_E_clear = 1'b0;
      E_M_RegWE = 1'b1;
      E_M_clear = 1'b0;
      M_W_RegWE = 1'b1;
      M_W_clear = 1'b0;
      if (flush_req) begin
         F_D_clear = 1'b1;
         D_E_clear = 1'b1;
         E_M_clear = 1'b1;
      end else begin
         PC_RegWE  = ~stall_s;
         F_D_RegWE = ~stall_s;
         D_E_clear = stall_s;
      end
   end

   assign stall   = stall_s;
   assign md_busy = md_busy_s;

   // Mult/div busy counter next state; a start while busy is ignored and the
   // count keeps running through a flush because HI/LO commit is not cancelled.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (E_md_start && !md_busy_s) begin
         md_cnt_d = E_md_is_div ? DIV_LOAD : MUL_LOAD;
      end else if (md_busy_s) begin
         md_cnt_d = md_cnt_q - CW'(1);
      end else begin
         md_cnt_d = md_cnt_q;
      end
   end

   // Mult/div busy counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_cnt_q <= {CW{1'b0}};
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

`ifdef STALL_CNT_EN
   logic [SCW-1:0] stall_cnt_q;
   logic [SCW-1:0] stall_cnt_d;

   // Saturating stall counter next state.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_s && (stall_cnt_q != {SCW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + SCW'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= {SCW{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = {SCW{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit_v2.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_v2
//
// Directed self-checking bench for hazard_unit_v2 (NUM_PROD=2, TW=4, AW=5,
// MUL_CYCLES=5, DIV_CYCLES=10, SCW=4). Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit_v2;

   localparam int NUM_PROD = 2;
   localparam int TW       = 4;
   localparam int AW       = 5;
   localparam int SCW      = 4;

   logic                   clk;
   logic                   reset;
   logic [TW-1:0]          D_rs_Tuse;
   logic [TW-1:0]          D_rt_Tuse;
   logic [AW-1:0]          D_A1;
   logic [AW-1:0]          D_A2;
   logic [NUM_PROD*AW-1:0] P_A3;
   logic [NUM_PROD*TW-1:0] P_Tnew;
   logic [NUM_PROD-1:0]    P_RegWrite;
   logic                   D_md_use;
   logic                   E_md_start;
   logic                   E_md_is_div;
   logic                   flush_req;
   logic                   stall;
   logic                   PC_RegWE;
   logic                   F_D_RegWE;
   logic                   F_D_clear;
   logic                   D_E_RegWE;
   logic                   D_E_clear;
   logic                   E_M_RegWE;
   logic                   E_M_clear;
   logic                   M_W_RegWE;
   logic                   M_W_clear;
   logic                   md_busy;
   logic [SCW-1:0]         stall_cnt;

   int n_total;
   int n_pass;

   hazard_unit_v2 #(
      .NUM_PROD  (NUM_PROD),
      .TW        (TW),
      .AW        (AW),
      .MUL_CYCLES(5),
      .DIV_CYCLES(10),
      .SCW       (SCW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .D_rs_Tuse  (D_rs_Tuse),
      .D_rt_Tuse  (D_rt_Tuse),
      .D_A1       (D_A1),
      .D_A2       (D_A2),
      .P_A3       (P_A3),
      .P_Tnew     (P_Tnew),
      .P_RegWrite (P_RegWrite),
      .D_md_use   (D_md_use),
      .E_md_start (E_md_start),
      .E_md_is_div(E_md_is_div),
      .flush_req  (flush_req),
      .stall      (stall),
      .PC_RegWE   (PC_RegWE),
      .F_D_RegWE  (F_D_RegWE),
      .F_D_clear  (F_D_clear),
      .D_E_RegWE  (D_E_RegWE),
      .D_E_clear  (D_E_clear),
      .E_M_RegWE  (E_M_RegWE),
      .E_M_clear  (E_M_clear),
      .M_W_RegWE  (M_W_RegWE),
      .M_W_clear  (M_W_clear),
      .md_busy    (md_busy),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      D_rs_Tuse   = 4'd0;
      D_rt_Tuse   = 4'd0;
      D_A1        = 5'd0;
      D_A2        = 5'd0;
      P_A3        = 10'd0;
      P_Tnew      = 8'd0;
      P_RegWrite  = 2'b00;
      D_md_use    = 1'b0;
      E_md_start  = 1'b0;
      E_md_is_div = 1'b0;
      flush_req   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      #2;
      n_total++;
      if ({stall, PC_RegWE, F_D_RegWE, D_E_RegWE, E_M_RegWE, M_W_RegWE} !== 6'b011111) begin
         $display("FAIL reset_we: got %b expected 011111",
                  {stall, PC_RegWE, F_D_RegWE, D_E_RegWE, E_M_RegWE, M_W_RegWE});
      end else n_pass++;
      n_total++;
      if ({F_D_clear, D_E_clear, E_M_clear, M_W_clear, md_busy} !== 5'b00000) begin
         $display("FAIL reset_clr: got %b expected 00000",
                  {F_D_clear, D_E_clear, E_M_clear, M_W_clear, md_busy});
      end else n_pass++;
      n_total++;
      if (stall_cnt !== 4'd0) begin
         $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
      end else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_load_use();
      @(negedge clk);
      clear_inputs();
      P_A3       = {5'd0, 5'd8};
      P_Tnew     = {4'd0, 4'd2};
      P_RegWrite = 2'b01;
      D_A1       = 5'd8;
      D_rs_Tuse  = 4'd0;
      #1;
      n_total++;
      if ({stall, PC_RegWE, F_D_RegWE, D_E_clear, D_E_RegWE, E_M_RegWE, F_D_clear} !== 7'b1001110) begin
         $display("FAIL load_use: got %b expected 1001110",
                  {stall, PC_RegWE, F_D_RegWE, D_E_clear, D_E_RegWE, E_M_RegWE, F_D_clear});
      end else n_pass++;
      // Boundary: Tuse == Tnew does not stall.
      D_rs_Tuse = 4'd2;
      #1;
      n_total++;
      if (stall !== 1'b0) begin
         $display("FAIL tuse_eq_tnew: got %b expected 0", stall);
      end else n_pass++;
      D_rs_Tuse = 4'd1;
      #1;
      n_total++;
      if (stall !== 1'b1) begin
         $display("FAIL tuse_lt_tnew: got %b expected 1", stall);
      end else n_pass++;
      // $zero never stalls.
      D_rs_Tuse  = 4'd0;
      D_A1       = 5'd0;
      P_A3       = {5'd0, 5'd0};
      #1;
      n_total++;
      if (stall !== 1'b0) begin
         $display("FAIL zero_reg: got %b expected 0", stall);
      end else n_pass++;
      // Producer not writing never stalls.
      D_A1       = 5'd8;
      P_A3       = {5'd0, 5'd8};
      P_RegWrite = 2'b00;
      #1;
      n_total++;
      if (stall !== 1'b0) begin
         $display("FAIL no_regwrite: got %b expected 0", stall);
      end else n_pass++;
   endtask

   task automatic test_m_stage();
      @(negedge clk);
      clear_inputs();
      P_A3       = {5'd9, 5'd3};
      P_Tnew     = {4'd1, 4'd0};
      P_RegWrite = 2'b10;
      D_A2       = 5'd9;
      D_rt_Tuse  = 4'd0;
      #1;
      n_total++;
      if ({stall, F_D_RegWE, D_E_clear} !== 3'b101) begin
         $display("FAIL m_stage_hit: got %b expected 101", {stall, F_D_RegWE, D_E_clear});
      end else n_pass++;
      D_rt_Tuse = 4'd1;
      #1;
      n_total++;
      if (stall !== 1'b0) begin
         $display("FAIL m_stage_tuse1: got %b expected 0", stall);
      end else n_pass++;
      // Mismatching address on rt.
      D_rt_Tuse = 4'd0;
      D_A2      = 5'd3;
      #1;
      n_total++;
      if (stall !== 1'b0) begin
         $display("FAIL m_stage_miss: got %b expected 0", stall);
      end else n_pass++;
   endtask

   task automatic run_md(input logic is_div, input int cycles, input string nm);
      int busy_seen;
      int stall_seen;
      busy_seen  = 0;
      stall_seen = 0;
      @(negedge clk);
      clear_inputs();
      E_md_start  = 1'b1;
      E_md_is_div = is_div;
      D_md_use    = 1'b1;
      #1;
      n_total++;
      if ({stall, md_busy} !== 2'b10) begin
         $display("FAIL %s_start: got %b expected 10", nm, {stall, md_busy});
      end else n_pass++;
      stall_seen++;
      @(negedge clk);
      E_md_start  = 1'b0;
      E_md_is_div = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         if (md_busy === 1'b1) busy_seen++;
         if (stall === 1'b1) stall_seen++;
         @(negedge clk);
      end
      n_total++;
      if (busy_seen !== cycles) begin
         $display("FAIL %s_busy_cycles: got %0d expected %0d", nm, busy_seen, cycles);
      end else n_pass++;
      n_total++;
      if (stall_seen !== cycles + 1) begin
         $display("FAIL %s_stall_cycles: got %0d expected %0d", nm, stall_seen, cycles + 1);
      end else n_pass++;
      #1;
      n_total++;
      if ({stall, md_busy} !== 2'b00) begin
         $display("FAIL %s_release: got %b expected 00", nm, {stall, md_busy});
      end else n_pass++;
   endtask

   task automatic test_multiply();
      run_md(1'b0, 5, "mult");
   endtask

   task automatic test_divide();
      run_md(1'b1, 10, "div");
   endtask

   task automatic test_flush();
      @(negedge clk);
      clear_inputs();
      P_A3       = {5'd0, 5'd8};
      P_Tnew     = {4'd0, 4'd2};
      P_RegWrite = 2'b01;
      D_A1       = 5'd8;
      flush_req  = 1'b1;
      #1;
      n_total++;
      if ({stall, PC_RegWE, F_D_RegWE, D_E_RegWE, E_M_RegWE, M_W_RegWE} !== 6'b011111) begin
         $display("FAIL flush_we: got %b expected 011111",
                  {stall, PC_RegWE, F_D_RegWE, D_E_RegWE, E_M_RegWE, M_W_RegWE});
      end else n_pass++;
      n_total++;
      if ({F_D_clear, D_E_clear, E_M_clear, M_W_clear} !== 4'b1110) begin
         $display("FAIL flush_clr: got %b expected 1110",
                  {F_D_clear, D_E_clear, E_M_clear, M_W_clear});
      end else n_pass++;
      // Mult counter keeps running under flush.
      clear_inputs();
      E_md_start = 1'b1;
      flush_req  = 1'b1;
      @(negedge clk);
      E_md_start = 1'b0;
      @(negedge clk);
      #1;
      n_total++;
      if (md_busy !== 1'b1) begin
         $display("FAIL flush_md_count: got %b expected 1", md_busy);
      end else n_pass++;
      repeat (5) @(negedge clk);
      flush_req = 1'b0;
   endtask

   task automatic test_reset_mid_divide();
      @(negedge clk);
      clear_inputs();
      E_md_start  = 1'b1;
      E_md_is_div = 1'b1;
      D_md_use    = 1'b1;
      @(negedge clk);
      E_md_start  = 1'b0;
      E_md_is_div = 1'b0;
      // md_cnt is 10 here; six more edges bring it to 4.
      repeat (6) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_total++;
      if ({md_busy, stall} !== 2'b00) begin
         $display("FAIL reset_mid_div: got %b expected 00", {md_busy, stall});
      end else n_pass++;
      n_total++;
      if (stall_cnt !== 4'd0) begin
         $display("FAIL reset_mid_div_cnt: got %0d expected 0", stall_cnt);
      end else n_pass++;
      clear_inputs();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_stall_cnt();
      logic [SCW-1:0] exp5;
      logic [SCW-1:0] exp15;
`ifdef STALL_CNT_EN
      exp5  = 4'd5;
      exp15 = 4'd15;
`else
      exp5  = 4'd0;
      exp15 = 4'd0;
`endif
      @(negedge clk);
      clear_inputs();
      P_A3       = {5'd0, 5'd8};
      P_Tnew     = {4'd0, 4'd2};
      P_RegWrite = 2'b01;
      D_A1       = 5'd8;
      repeat (5) @(negedge clk);
      #1;
      n_total++;
      if (stall_cnt !== exp5) begin
         $display("FAIL stall_cnt_5: got %0d expected %0d", stall_cnt, exp5);
      end else n_pass++;
      repeat (15) @(negedge clk);
      #1;
      n_total++;
      if (stall_cnt !== exp15) begin
         $display("FAIL stall_cnt_sat: got %0d expected %0d", stall_cnt, exp15);
      end else n_pass++;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (stall_cnt !== exp15) begin
         $display("FAIL stall_cnt_hold: got %0d expected %0d", stall_cnt, exp15);
      end else n_pass++;
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [SCW-1:0] before_cnt;
      logic [SCW-1:0] exp_cnt;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      @(negedge clk);
      clear_inputs();
      before_cnt = stall_cnt;
      // Register hazard and md hazard together: one stall, one increment.
      P_A3       = {5'd0, 5'd8};
      P_Tnew     = {4'd0, 4'd2};
      P_RegWrite = 2'b01;
      D_A1       = 5'd8;
      D_md_use   = 1'b1;
      E_md_start = 1'b1;
      #1;
      n_total++;
      if (stall !== 1'b1) begin
         $display("FAIL both_hazards: got %b expected 1", stall);
      end else n_pass++;
      @(negedge clk);
      clear_inputs();
`ifdef STALL_CNT_EN
      exp_cnt = 4'd1;
`else
      exp_cnt = 4'd0;
`endif
      #1;
      n_total++;
      if (stall_cnt !== exp_cnt) begin
         $display("FAIL both_hazards_cnt: got %0d expected %0d (before %0d)",
                  stall_cnt, exp_cnt, before_cnt);
      end else n_pass++;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      test_reset();
      test_load_use();
      test_m_stage();
      test_multiply();
      test_divide();
      test_flush();
      test_reset_mid_divide();
      test_stall_cnt();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
